idli_sqi_ctrl_m: RTL and testbench

- Nibble-serial SQI (quad-SPI) SRAM host controller. It is the producer/consumer end of the 4b-per-cycle datapath: it moves 16b words between external SQI SRAM and the core as four sqi_data_t nibbles, one per cycle, in the same order the serial ALU consumes them.
- Sits between the core's memory request logic and the SQI pads.
- Issues READ (0x03) and WRITE (0x02) commands in sequential mode, with optional multi-word bursts.

---
 rtl/idli_sqi_ctrl_m.sv | 117 +++++++++++
 tb/tb_idli_sqi_ctrl_m.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/idli_sqi_ctrl_m.sv
// idli_sqi_ctrl_m: nibble-serial SQI (quad-SPI) SRAM host controller.
// Issues READ (0x03) / WRITE (0x02) in sequential mode. Each word is moved as four
// nibbles per 16b word, with optional multi-word bursts.
// Ports:
//   i_sqi_gck, i_sqi_rst_n           clock, asynchronous active-low reset
//   i_sqi_req, i_sqi_wr, i_sqi_addr  core request, direction, word address
//   o_sqi_ack                        request accepted (combinational, IDLE only)
//   i_sqi_cont                       continue burst, sampled on the last nibble of a word
//   i_sqi_wr_data, o_sqi_wr_rdy      write nibble, consumed every write DATA cycle
//   o_sqi_rd_data, o_sqi_rd_vld      registered read nibble and its valid
//   o_sqi_cs_n, o_sqi_sck_en         chip select (active low), SCK gate enable
//   o_sqi_sio, o_sqi_sio_oe          SIO output nibble and output enable
//   i_sqi_sio                        SIO input nibble
module idli_sqi_ctrl_m #(
    parameter int DUMMY_NIBBLES = 2
) (
    input  logic        i_sqi_gck,
    input  logic        i_sqi_rst_n,
    input  logic        i_sqi_req,
    input  logic        i_sqi_wr,
    input  logic [15:0] i_sqi_addr,
    output logic        o_sqi_ack,
    input  logic        i_sqi_cont,
    input  logic [3:0]  i_sqi_wr_data,
    output logic        o_sqi_wr_rdy,
    output logic [3:0]  o_sqi_rd_data,
    output logic        o_sqi_rd_vld,
    output logic        o_sqi_cs_n,
    output logic        o_sqi_sck_en,
    output logic [3:0]  o_sqi_sio,
    output logic        o_sqi_sio_oe,
    input  logic [3:0]  i_sqi_sio
);
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_END} state_t;

    localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_NIBBLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic        r_wr;
    logic [23:0] r_addr;
    logic [3:0]  r_sio;
    logic [3:0]  w_sio_nxt;
    logic [3:0]  r_rd_data;
    logic        r_rd_vld;
    logic        w_active;
    logic        w_data_wr;
    logic        w_data_rd;
    logic [23:0] w_addr_sh;

    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = i_sqi_req ? S_CMD : S_IDLE;
            S_CMD:   w_state_nxt = (r_cnt == 3'd1) ? S_ADDR : S_CMD;
            S_ADDR:  w_state_nxt = (r_cnt == 3'd5) ? (r_wr ? S_DATA : S_DUMMY) : S_ADDR;
            S_DUMMY: w_state_nxt = (r_cnt == DUMMY_LAST) ? S_DATA : S_DUMMY;
            S_DATA:  w_state_nxt = (r_cnt == 3'd3 && !i_sqi_cont) ? S_END : S_DATA;
            S_END:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Counter restarts on every state change and at each word boundary of a burst.
    assign w_cnt_nxt = (w_state_nxt != r_state || r_state == S_IDLE ||
                        (r_state == S_DATA && r_cnt == 3'd3)) ? 3'd0 : r_cnt + 3'd1;

    // Nibble to present next cycle: opcode high nibble is 0 for both commands,
    // low nibble is 3 (read) or 2 (write); address goes out MS nibble first.
    assign w_addr_sh = r_addr << {w_cnt_nxt, 2'b00};
    assign w_sio_nxt = (w_state_nxt == S_CMD)  ? ((w_cnt_nxt == 3'd0) ? 4'h0 : {3'b001, ~r_wr}) :
                       (w_state_nxt == S_ADDR) ? w_addr_sh[23:20] : 4'h0;

    assign w_active  = (r_state != S_IDLE) && (r_state != S_END);
    assign w_data_wr = (r_state == S_DATA) && r_wr;
    assign w_data_rd = (r_state == S_DATA) && !r_wr;

    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            r_wr      <= 1'b0;
            r_addr    <= 24'd0;
            r_sio     <= 4'h0;
            r_rd_data <= 4'h0;
            r_rd_vld  <= 1'b0;
        end else begin
            r_sio    <= w_sio_nxt;
            r_rd_vld <= w_data_rd;
            if (w_data_rd) r_rd_data <= i_sqi_sio;
            if (r_state == S_IDLE && i_sqi_req) begin
                r_wr   <= i_sqi_wr;
                r_addr <= {7'b0, i_sqi_addr, 1'b0};
            end
        end
    end

    assign o_sqi_ack     = (r_state == S_IDLE) && i_sqi_req;
    assign o_sqi_cs_n    = !w_active;
    assign o_sqi_sck_en  = w_active;
    assign o_sqi_sio_oe  = (r_state == S_CMD) || (r_state == S_ADDR) || w_data_wr;
    // Write data streams straight from the core with no extra pipeline stage.
    assign o_sqi_sio     = w_data_wr ? i_sqi_wr_data : r_sio;
    assign o_sqi_wr_rdy  = w_data_wr;
    assign o_sqi_rd_data = r_rd_data;
    assign o_sqi_rd_vld  = r_rd_vld;
endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// tb_idli_sqi_ctrl_m: randomized self-checking bench for idli_sqi_ctrl_m with a
// transaction-timeline reference model, run on DUMMY_NIBBLES=2 and =5 instances.
module tb_idli_sqi_ctrl_m;
    typedef struct {
        logic       ack, cs_n, sck, oe, rdy, vld, chk_rd;
        logic [3:0] sio, rd;
    } exp_t;

    localparam int HN = 8192;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, wr = 1'b0, cont = 1'b0, sel = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [3:0]  wdata = 4'h0, sio_in = 4'h0;

    logic       ack_o[2], rdy_o[2], vld_o[2], csn_o[2], sck_o[2], oe_o[2];
    logic [3:0] rd_o[2], sio_o[2];

    exp_t exp_q[$];
    int   errors = 0, checks = 0, cyc = 0, t0 = 0;

    logic       h_ack[HN], h_csn[HN], h_sck[HN], h_oe[HN], h_rdy[HN], h_vld[HN];
    logic [3:0] h_sio[HN], h_rd[HN];

    always #5 clk = ~clk;

    idli_sqi_ctrl_m #(.DUMMY_NIBBLES(2)) u_dut2 (
        .i_sqi_gck(clk), .i_sqi_rst_n(rst_n), .i_sqi_req(req & !sel), .i_sqi_wr(wr),
        .i_sqi_addr(addr), .o_sqi_ack(ack_o[0]), .i_sqi_cont(cont), .i_sqi_wr_data(wdata),
        .o_sqi_wr_rdy(rdy_o[0]), .o_sqi_rd_data(rd_o[0]), .o_sqi_rd_vld(vld_o[0]),
        .o_sqi_cs_n(csn_o[0]), .o_sqi_sck_en(sck_o[0]), .o_sqi_sio(sio_o[0]),
        .o_sqi_sio_oe(oe_o[0]), .i_sqi_sio(sio_in)
    );

    idli_sqi_ctrl_m #(.DUMMY_NIBBLES(5)) u_dut5 (
        .i_sqi_gck(clk), .i_sqi_rst_n(rst_n), .i_sqi_req(req & sel), .i_sqi_wr(wr),
        .i_sqi_addr(addr), .o_sqi_ack(ack_o[1]), .i_sqi_cont(cont), .i_sqi_wr_data(wdata),
        .o_sqi_wr_rdy(rdy_o[1]), .o_sqi_rd_data(rd_o[1]), .o_sqi_rd_vld(vld_o[1]),
        .o_sqi_cs_n(csn_o[1]), .o_sqi_sck_en(sck_o[1]), .o_sqi_sio(sio_o[1]),
        .o_sqi_sio_oe(oe_o[1]), .i_sqi_sio(sio_in)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, ex);
        end
    endtask

    function automatic int hi(input int c);
        return c % HN;
    endfunction

    function automatic exp_t mk(input logic ack, cs_n, sck, oe, input logic [3:0] sio,
                                input logic rdy, vld, chk_rd, input logic [3:0] rd);
        exp_t e;
        e.ack = ack; e.cs_n = cs_n; e.sck = sck; e.oe = oe; e.sio = sio;
        e.rdy = rdy; e.vld = vld; e.chk_rd = chk_rd; e.rd = rd;
        return e;
    endfunction

    // Compare the selected instance against the model on every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ack", ack_o[sel], e.ack);
            chk("cs_n", csn_o[sel], e.cs_n);
            chk("sck_en", sck_o[sel], e.sck);
            chk("sio_oe", oe_o[sel], e.oe);
            chk("sio", sio_o[sel], e.sio);
            chk("wr_rdy", rdy_o[sel], e.rdy);
            chk("rd_vld", vld_o[sel], e.vld);
            if (e.chk_rd) chk("rd_data", rd_o[sel], e.rd);
        end
        h_ack[hi(cyc)] = ack_o[sel]; h_csn[hi(cyc)] = csn_o[sel]; h_sck[hi(cyc)] = sck_o[sel];
        h_oe[hi(cyc)]  = oe_o[sel];  h_rdy[hi(cyc)] = rdy_o[sel]; h_vld[hi(cyc)] = vld_o[sel];
        h_sio[hi(cyc)] = sio_o[sel]; h_rd[hi(cyc)]  = rd_o[sel];
        cyc++;
    end

    task automatic noise();
        req = 1'($urandom); wr = 1'($urandom); addr = 16'($urandom);
        cont = 1'($urandom); wdata = 4'($urandom); sio_in = 4'($urandom);
    endtask

    task automatic rst_cycle();
        @(posedge clk); #1;
        noise(); req = 1'b0; rst_n = 1'b0;
        exp_q.push_back(mk(0, 1, 0, 0, 4'h0, 0, 0, 1, 4'h0));
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        noise(); req = 1'b0; rst_n = 1'b1;
        exp_q.push_back(mk(0, 1, 0, 0, 4'h0, 0, 0, 0, 4'h0));
    endtask

    // One transaction from the accept cycle (t=0) through END, timeline from the rules:
    // CMD 2, ADDR 6, DUMMY (reads), 4 DATA nibbles per word, END 1.
    task automatic run_txn(input logic s, input logic w, input logic [15:0] a, input int n,
                           input logic [63:0] d, input int abort_t, input logic hold);
        int          dn, len, j;
        logic [23:0] ba;
        exp_t        e;
        dn  = w ? 0 : (s ? 5 : 2);
        len = 10 + dn + 4 * n;
        ba  = {7'b0, a, 1'b0};
        for (int t = 0; t < len; t++) begin
            @(posedge clk); #1;
            noise();
            if (hold) req = 1'b1;
            j = t - 9 - dn;
            if (t == 0) begin
                sel = s; req = 1'b1; wr = w; addr = a; t0 = cyc;
            end
            if (j >= 0 && j < 4 * n) begin
                if (w) wdata = d[4*j +: 4];
                else sio_in = d[4*j +: 4];
                if (j % 4 == 3) cont = (j / 4 < n - 1);
            end
            if (t == abort_t) begin
                rst_n = 1'b0; req = 1'b0;
                exp_q.push_back(mk(0, 1, 0, 0, 4'h0, 0, 0, 1, 4'h0));
                return;
            end
            if (t == 0)           e = mk(1, 1, 0, 0, 4'h0, 0, 0, 0, 4'h0);
            else if (t <= 2)      e = mk(0, 0, 1, 1, (t == 1) ? 4'h0 : (w ? 4'h2 : 4'h3), 0, 0, 0, 4'h0);
            else if (t <= 8)      e = mk(0, 0, 1, 1, ba[4*(8-t) +: 4], 0, 0, 0, 4'h0);
            else if (t < 9 + dn)  e = mk(0, 0, 1, 0, 4'h0, 0, 0, 0, 4'h0);
            else if (j < 4 * n)   e = w ? mk(0, 0, 1, 1, d[4*j +: 4], 1, 0, 0, 4'h0)
                                        : mk(0, 0, 1, 0, 4'h0, 0, j > 0, j > 0, (j > 0) ? d[4*(j-1) +: 4] : 4'h0);
            else                  e = mk(0, 1, 0, 0, 4'h0, 0, !w, !w, d[4*(4*n-1) +: 4]);
            exp_q.push_back(e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1);
    end

    initial begin
        logic [3:0]  lit_r[8]  = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h2, 4'h4, 4'h6, 4'h8};
        logic [3:0]  lit_w[12] = '{4'h0, 4'h2, 4'h0, 4'h1, 4'hF, 4'hF, 4'hF, 4'hE,
                                   4'h1, 4'h2, 4'h3, 4'h4};
        logic [3:0]  lit_d[4]  = '{4'hA, 4'hB, 4'hC, 4'hD};
        int          tb, cnt, gap;
        for (int i = 0; i < 3; i++) rst_cycle();
        for (int i = 0; i < 2; i++) idle_cycle();

        run_txn(0, 0, 16'h1234, 1, 64'hDCBA, -1, 0);
        idle_cycle();
        for (int k = 0; k < 8; k++) chk("rd_cmd_addr_sio", h_sio[hi(t0+1+k)], lit_r[k]);
        for (int k = 0; k < 4; k++) begin
            chk("rd_vld_lit", h_vld[hi(t0+12+k)], 1);
            chk("rd_data_lit", h_rd[hi(t0+12+k)], lit_d[k]);
        end
        chk("rd_cs_low_14", h_csn[hi(t0+14)], 0);
        chk("rd_cs_high_15", h_csn[hi(t0+15)], 1);

        run_txn(0, 1, 16'hFFFF, 1, 64'h4321, -1, 0);
        idle_cycle();
        for (int k = 0; k < 12; k++) chk("wr_sio_lit", h_sio[hi(t0+1+k)], lit_w[k]);
        for (int k = 9; k <= 12; k++) chk("wr_rdy_lit", h_rdy[hi(t0+k)], 1);
        chk("wr_end_cs", h_csn[hi(t0+13)], 1);
        chk("wr_end_oe", h_oe[hi(t0+13)], 0);

        run_txn(0, 0, 16'($urandom), 2, {32'h0, $urandom}, -1, 0);
        idle_cycle();
        cnt = 0;
        for (int k = 0; k <= 20; k++) cnt += int'(h_vld[hi(t0+k)]);
        chk("burst_vld_count", cnt, 8);
        cnt = 0;
        for (int k = 1; k <= 18; k++) cnt += int'(h_csn[hi(t0+k)]);
        chk("burst_cs_low", cnt, 0);
        chk("burst_end_once", h_csn[hi(t0+19)], 1);

        run_txn(0, 1, 16'($urandom), 1, {32'h0, $urandom}, -1, 1);
        tb = t0;
        run_txn(0, 1, 16'($urandom), 1, {32'h0, $urandom}, -1, 1);
        idle_cycle();
        chk("b2b_no_ack_13", h_ack[hi(tb+13)], 0);
        chk("b2b_ack_14", h_ack[hi(tb+14)], 1);
        chk("b2b_cs_13", h_csn[hi(tb+13)], 1);
        chk("b2b_cs_14", h_csn[hi(tb+14)], 1);

        run_txn(1, 0, 16'($urandom), 1, {32'h0, $urandom}, -1, 0);
        idle_cycle();
        for (int k = 9; k <= 13; k++) chk("dn5_oe_low", h_oe[hi(t0+k)], 0);
        chk("dn5_no_vld_14", h_vld[hi(t0+14)], 0);
        for (int k = 15; k <= 18; k++) chk("dn5_vld", h_vld[hi(t0+k)], 1);

        run_txn(0, 0, 16'($urandom), 1, {32'h0, $urandom}, 5, 0);
        for (int i = 0; i < 2; i++) rst_cycle();
        chk("rst_cs_n", h_csn[hi(t0+5)], 1);
        chk("rst_oe", h_oe[hi(t0+5)], 0);
        chk("rst_sck", h_sck[hi(t0+5)], 0);
        idle_cycle();
        run_txn(0, 1, 16'($urandom), 1, {32'h0, $urandom}, -1, 0);
        idle_cycle();
        chk("post_rst_ack", h_ack[hi(t0)], 1);

        for (int k = 0; k < 60; k++) begin
            run_txn(1'($urandom), 1'($urandom), 16'($urandom), int'($urandom_range(1, 3)),
                    {$urandom, $urandom}, -1, 0);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) idle_cycle();
        end

        idle_cycle();
        idle_cycle();
        @(posedge clk); #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
